// File: rtl/srl_fifo_param_if.sv
// srl_fifo_param_if: stream interface for srl_fifo_param.
//
// Handshake semantics (both directions are HLS-style request/status):
//   write side : a word on if_din is accepted on a rising clk edge when
//                if_write=1 and if_full_n=1; if_write with if_full_n=0 is ignored.
//   read side  : if_dout holds the head word whenever if_empty_n=1; the head
//                is consumed on a rising clk edge when if_read=1 and
//                if_empty_n=1; if_read with if_empty_n=0 is ignored.
//   if_full_n and if_empty_n are registered and never depend combinationally
//   on if_write or if_read.
interface srl_fifo_param_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  if_write;
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_full_n;
    logic                  if_read;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  if_empty_n;

    // Producer/consumer side of the stream.
    modport master (
        output if_write,
        output if_din,
        output if_read,
        input  if_full_n,
        input  if_dout,
        input  if_empty_n
    );

    // FIFO side of the stream.
    modport slave (
        input  if_write,
        input  if_din,
        input  if_read,
        output if_full_n,
        output if_dout,
        output if_empty_n
    );
endinterface

// File: rtl/srl_fifo_param.sv
// srl_fifo_param: parametrised shift-register FIFO for inter-PE streams.
//
// Storage shifts by one entry on every accepted write; the head of the queue
// is addressed by the SRL occupancy, so there are no read/write pointers and
// no wrap-around. Provides full_n/empty_n status, an occupancy count and
// registered almost_full / almost_empty flags.
//
// Optional feature, macro SRL_FIFO_OUTREG_EN:
//   defined   -> a registered output stage (oreg/ovalid) follows the SRL;
//                two-cycle write-to-read latency, capacity DEPTH+1.
//   undefined -> first-word fall-through straight from the SRL head,
//                one-cycle write-to-read latency, capacity DEPTH.
module srl_fifo_param #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    srl_fifo_param_if.slave       fifo_if,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam int              CW          = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]   DEPTH_C     = CW'(DEPTH);
    localparam logic            AF_AT_RESET = (AF_LEVEL == 0);

    // SRL storage: mem[0] is the newest entry, mem[count_srl-1] the oldest.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]         count_srl;
    logic [CW-1:0]         count_srl_nxt;
    logic [CW-1:0]         count_nxt;
    logic [31:0]           count_nxt_w;
    logic                  full_n_r;
    logic                  push;
    logic                  pop;
    logic                  srl_pop;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] srl_head;

    // A write is only taken when the SRL has room; the full flag is
    // registered, so the qualification never sees same-cycle pops.
    assign push = fifo_if.if_write & full_n_r;

    assign fifo_if.if_full_n = full_n_r;

    // Head entry address; with an empty SRL the address is parked at 0 so
    // the index always stays inside the storage array.
    assign rd_addr  = (count_srl == '0) ? '0 : ADDR_WIDTH'(count_srl - 1'b1);
    assign srl_head = mem[rd_addr];

`ifdef SRL_FIFO_OUTREG_EN
    logic                  ovalid;
    logic                  ovalid_nxt;
    logic [DATA_WIDTH-1:0] oreg;

    // The consumer pops the output register, not the SRL.
    assign pop = fifo_if.if_read & ovalid;

    // The SRL head moves into oreg whenever oreg is free or being emptied.
    // A write never bypasses the SRL, even when both stages are empty.
    assign srl_pop    = (count_srl != '0) & (~ovalid | pop);
    assign ovalid_nxt = srl_pop | (ovalid & ~pop);

    assign fifo_if.if_dout    = oreg;
    assign fifo_if.if_empty_n = ovalid;

    // Reported occupancy includes the word parked in oreg.
    assign count_nxt = count_srl_nxt + {{(CW-1){1'b0}}, ovalid_nxt};

    // Output register stage: load from SRL head or drain on pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oreg   <= '0;
            ovalid <= 1'b0;
        end else begin
            ovalid <= ovalid_nxt;
            if (srl_pop) begin
                oreg <= srl_head;
            end
        end
    end
`else
    logic empty_n_r;

    // Fall-through: the SRL head is the output and the consumer pops the SRL.
    assign pop     = fifo_if.if_read & empty_n_r;
    assign srl_pop = pop;

    assign fifo_if.if_dout    = srl_head;
    assign fifo_if.if_empty_n = empty_n_r;

    assign count_nxt = count_srl_nxt;

    // Registered empty status derived from the next SRL occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            empty_n_r <= 1'b0;
        end else begin
            empty_n_r <= (count_srl_nxt != '0);
        end
    end
`endif

    // Next SRL occupancy. A simultaneous push and pop leaves the address
    // unchanged while the shift moves the next-oldest word under it.
    always_comb begin
        count_srl_nxt = count_srl;
        case ({push, srl_pop})
            2'b10:   count_srl_nxt = count_srl + 1'b1;
            2'b01:   count_srl_nxt = count_srl - 1'b1;
            default: count_srl_nxt = count_srl;
        endcase
    end

    assign count_nxt_w = 32'(count_nxt);

    // Shift register storage; deliberately not reset so it maps onto SRLs.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[0] <= fifo_if.if_din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    // Occupancy, full status and level flags, all registered from the
    // next-state count so they change on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_srl    <= '0;
            full_n_r     <= 1'b1;
            count        <= '0;
            almost_full  <= AF_AT_RESET;
            almost_empty <= 1'b1;
        end else begin
            count_srl    <= count_srl_nxt;
            full_n_r     <= (count_srl_nxt != DEPTH_C);
            count        <= count_nxt;
            almost_full  <= (count_nxt_w >= $unsigned(AF_LEVEL));
            almost_empty <= (count_nxt_w <= $unsigned(AE_LEVEL));
        end
    end

endmodule

// File: tb/tb_srl_fifo_param.sv
// tb_srl_fifo_param: self-checking bench for srl_fifo_param
// (DEPTH=4, DATA_WIDTH=8, AF_LEVEL=3, AE_LEVEL=1), builds with or without
// SRL_FIFO_OUTREG_EN. The reference model holds the queued words in a
// queue plus a "head visible" bit for the output register stage.
module tb_srl_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int AF    = 3;
    localparam int AE    = 1;
`ifdef SRL_FIFO_OUTREG_EN
    localparam bit OREG = 1'b1;
`else
    localparam bit OREG = 1'b0;
`endif
    localparam int CAP = DEPTH + (OREG ? 1 : 0);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    srl_fifo_param_if #(.DATA_WIDTH(DW)) fifo_if ();
    logic [AW:0] count;
    logic        almost_full;
    logic        almost_empty;

    srl_fifo_param #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .fifo_if      (fifo_if),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    // ---------------- scoreboard / model ----------------
    logic [DW-1:0] exp_q[$];
    bit            m_vis;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit model_empty_n();
        return OREG ? m_vis : (exp_q.size() != 0);
    endfunction

    task automatic check_outputs(input string tag);
        int sz;
        int srl;
        sz  = exp_q.size();
        srl = sz - (OREG ? int'(m_vis) : 0);
        chk({tag, ".count"},   32'(count),                   32'(sz));
        chk({tag, ".empty_n"}, 32'(fifo_if.if_empty_n),      32'(model_empty_n()));
        chk({tag, ".full_n"},  32'(fifo_if.if_full_n),       32'(srl != DEPTH));
        chk({tag, ".af"},      32'(almost_full),             32'(sz >= AF));
        chk({tag, ".ae"},      32'(almost_empty),            32'(sz <= AE));
        if (model_empty_n()) begin
            chk({tag, ".dout"}, {24'h0, fifo_if.if_dout}, {24'h0, exp_q[0]});
        end
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; drives one cycle of requests and advances
    // the model on the rising edge, returning at the next falling edge.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
        int srl;
        bit push;
        bit pop;
        fifo_if.if_write = w;
        fifo_if.if_din   = d;
        fifo_if.if_read  = r;
        srl  = exp_q.size() - (OREG ? int'(m_vis) : 0);
        push = w && (srl != DEPTH);
        pop  = r && model_empty_n();
        @(posedge clk);
        if (pop) void'(exp_q.pop_front());
        if (push) exp_q.push_back(d);
        if (OREG) m_vis = (srl > 0) || (m_vis && !pop);
        @(negedge clk);
        fifo_if.if_write = 1'b0;
        fifo_if.if_read  = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < CAP + 2; i++) begin
            step(1'b0, '0, 1'b1);
            check_outputs(tag);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          w;
        logic [DW-1:0] d;
        logic          r;
        int            cnt;
        logic          en;
        logic          fn;
        logic          af;
        logic          ae;
        logic [DW-1:0] dout;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(logic w, logic [DW-1:0] d, logic r, int cnt,
                                logic en, logic fn, logic af, logic ae, logic [DW-1:0] dout);
        vec_t v;
        v.w = w; v.d = d; v.r = r; v.cnt = cnt;
        v.en = en; v.fn = fn; v.af = af; v.ae = ae; v.dout = dout;
        return v;
    endfunction

    initial begin
        reset_n          = 1'b0;
        fifo_if.if_write = 1'b0;
        fifo_if.if_din   = '0;
        fifo_if.if_read  = 1'b0;
        m_vis            = 1'b0;

`ifdef SRL_FIFO_OUTREG_EN
        tbl[0]  = mk(1, 8'hA1, 0, 1, 0, 1, 0, 1, 8'h00);
        tbl[1]  = mk(1, 8'hA2, 0, 2, 1, 1, 0, 0, 8'hA1);
        tbl[2]  = mk(1, 8'hA3, 0, 3, 1, 1, 1, 0, 8'hA1);
        tbl[3]  = mk(1, 8'hA4, 0, 4, 1, 1, 1, 0, 8'hA1);
        tbl[4]  = mk(1, 8'hA5, 0, 5, 1, 0, 1, 0, 8'hA1);
        tbl[5]  = mk(1, 8'hA6, 0, 5, 1, 0, 1, 0, 8'hA1);
        tbl[6]  = mk(0, 8'h00, 1, 4, 1, 1, 1, 0, 8'hA2);
        tbl[7]  = mk(0, 8'h00, 1, 3, 1, 1, 1, 0, 8'hA3);
        tbl[8]  = mk(0, 8'h00, 1, 2, 1, 1, 0, 0, 8'hA4);
        tbl[9]  = mk(0, 8'h00, 1, 1, 1, 1, 0, 1, 8'hA5);
        tbl[10] = mk(0, 8'h00, 1, 0, 0, 1, 0, 1, 8'h00);
        tbl[11] = mk(0, 8'h00, 1, 0, 0, 1, 0, 1, 8'h00);
`else
        tbl[0]  = mk(1, 8'hA1, 0, 1, 1, 1, 0, 1, 8'hA1);
        tbl[1]  = mk(1, 8'hA2, 0, 2, 1, 1, 0, 0, 8'hA1);
        tbl[2]  = mk(1, 8'hA3, 0, 3, 1, 1, 1, 0, 8'hA1);
        tbl[3]  = mk(1, 8'hA4, 0, 4, 1, 0, 1, 0, 8'hA1);
        tbl[4]  = mk(1, 8'hA5, 0, 4, 1, 0, 1, 0, 8'hA1);
        tbl[5]  = mk(1, 8'hA6, 0, 4, 1, 0, 1, 0, 8'hA1);
        tbl[6]  = mk(0, 8'h00, 1, 3, 1, 1, 1, 0, 8'hA2);
        tbl[7]  = mk(0, 8'h00, 1, 2, 1, 1, 0, 0, 8'hA3);
        tbl[8]  = mk(0, 8'h00, 1, 1, 1, 1, 0, 1, 8'hA4);
        tbl[9]  = mk(0, 8'h00, 1, 0, 0, 1, 0, 1, 8'h00);
        tbl[10] = mk(0, 8'h00, 1, 0, 0, 1, 0, 1, 8'h00);
        tbl[11] = mk(0, 8'h00, 1, 0, 0, 1, 0, 1, 8'h00);
`endif

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst.count",   32'(count),              32'd0);
        chk("rst.empty_n", 32'(fifo_if.if_empty_n), 32'd0);
        chk("rst.full_n",  32'(fifo_if.if_full_n),  32'd1);
        chk("rst.ae",      32'(almost_empty),       32'd1);
        chk("rst.af",      32'(almost_full),        32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Fill past capacity, then drain past empty.
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].w, tbl[i].d, tbl[i].r);
            chk($sformatf("tbl%0d.count", i),   32'(count),              32'(tbl[i].cnt));
            chk($sformatf("tbl%0d.empty_n", i), 32'(fifo_if.if_empty_n), 32'(tbl[i].en));
            chk($sformatf("tbl%0d.full_n", i),  32'(fifo_if.if_full_n),  32'(tbl[i].fn));
            chk($sformatf("tbl%0d.af", i),      32'(almost_full),        32'(tbl[i].af));
            chk($sformatf("tbl%0d.ae", i),      32'(almost_empty),       32'(tbl[i].ae));
            if (tbl[i].en) begin
                chk($sformatf("tbl%0d.dout", i), {24'h0, fifo_if.if_dout}, {24'h0, tbl[i].dout});
            end
        end

        // Streaming at constant occupancy 2.
        step(1'b1, 8'h21, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        check_outputs("hold.pre");
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'h30 + 8'(i), 1'b1);
            check_outputs("hold");
        end
        chk("hold.count_end", 32'(count), 32'd2);
        drain("hold.drain");

        // Write and read together while full.
        for (int i = 0; i < CAP; i++) begin
            step(1'b1, 8'h40 + 8'(i), 1'b0);
        end
        check_outputs("full.pre");
        chk("full.full_n_pre", 32'(fifo_if.if_full_n), 32'd0);
        step(1'b1, 8'hEE, 1'b1);
        chk("full.count_after", 32'(count), 32'(CAP - 1));
        chk("full.full_n_after", 32'(fifo_if.if_full_n), 32'd1);
        check_outputs("full.post");
        drain("full.drain");

        // Write and read together while empty.
        step(1'b1, 8'h5C, 1'b1);
        chk("empty.count", 32'(count), 32'd1);
        check_outputs("empty.post");
        if (OREG) step(1'b0, '0, 1'b0);
        chk("empty.empty_n", 32'(fifo_if.if_empty_n), 32'd1);
        chk("empty.dout", {24'h0, fifo_if.if_dout}, 32'h5C);
        step(1'b0, '0, 1'b1);
        check_outputs("empty.pop");

        // Asynchronous reset mid-stream at count 3.
        step(1'b1, 8'h61, 1'b0);
        step(1'b1, 8'h62, 1'b0);
        step(1'b1, 8'h63, 1'b0);
        chk("arst.count_pre", 32'(count), 32'd3);
        #2 reset_n = 1'b0;
        #1;
        chk("arst.count",   32'(count),              32'd0);
        chk("arst.empty_n", 32'(fifo_if.if_empty_n), 32'd0);
        chk("arst.full_n",  32'(fifo_if.if_full_n),  32'd1);
        chk("arst.ae",      32'(almost_empty),       32'd1);
        exp_q.delete();
        m_vis = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check_outputs("arst.idle");
        step(1'b1, 8'h77, 1'b0);
        if (OREG) step(1'b0, '0, 1'b0);
        chk("arst.dout_new", {24'h0, fifo_if.if_dout}, 32'h77);
        step(1'b0, '0, 1'b1);
        check_outputs("arst.pop");

        // Randomised traffic with varying write/read pressure.
        for (int seg = 0; seg < 4; seg++) begin
            int wp;
            int rp;
            wp = (seg % 2 == 0) ? 75 : 30;
            rp = (seg % 2 == 0) ? 30 : 75;
            for (int i = 0; i < 100; i++) begin
                step($urandom_range(0, 99) < wp, DW'($urandom), $urandom_range(0, 99) < rp);
                check_outputs("rand");
            end
        end
        drain("rand.drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
